// File: rtl/cg_rvarch_pkg.sv
// Shared types for the writeback path: register address, writeback request
// and the identity of each result source.
package cg_rvarch_pkg;

    localparam int XLEN    = 32;
    localparam int REG_NUM = 32;

    typedef logic [$clog2(REG_NUM)-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t        addr;
        logic [XLEN-1:0]  data;
    } wb_req_t;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/cg_rvarch_wb_arbiter_if.sv
// Result-producer handshakes and regfile write port of the writeback stage.
interface cg_rvarch_wb_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_NUM   = 32
);
    localparam int ADDR_W = $clog2(DATA_NUM);

    logic                  i_alu_valid;
    logic                  o_alu_ready;
    logic [ADDR_W-1:0]     i_alu_rd_addr;
    logic [DATA_WIDTH-1:0] i_alu_data;
    logic                  i_lsu_valid;
    logic                  o_lsu_ready;
    logic [ADDR_W-1:0]     i_lsu_rd_addr;
    logic [DATA_WIDTH-1:0] i_lsu_data;
    logic                  o_rd_we;
    logic [ADDR_W-1:0]     o_rd_addr;
    logic [DATA_WIDTH-1:0] o_rd_data;
    logic [DATA_NUM-1:0]   o_pend_mask;

    modport master (
        output i_alu_valid, i_alu_rd_addr, i_alu_data,
        output i_lsu_valid, i_lsu_rd_addr, i_lsu_data,
        input  o_alu_ready, o_lsu_ready,
        input  o_rd_we, o_rd_addr, o_rd_data, o_pend_mask
    );

    modport slave (
        input  i_alu_valid, i_alu_rd_addr, i_alu_data,
        input  i_lsu_valid, i_lsu_rd_addr, i_lsu_data,
        output o_alu_ready, o_lsu_ready,
        output o_rd_we, o_rd_addr, o_rd_data, o_pend_mask
    );

endinterface

// File: rtl/cg_rvarch_wb_slot.sv
// One-entry holding buffer for a single result source; a new result may be
// taken in the same cycle the held one is granted.
module cg_rvarch_wb_slot #(
    parameter int ADDR_W     = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_grant,
    output logic                  o_ready,
    output logic                  o_full,
    output logic [ADDR_W-1:0]     o_addr,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic                  full_q, full_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            full_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    // Load overrides the grant-clear so a back-to-back stream keeps the slot full.
    always_comb begin
        ready  = !full_q | i_grant;
        full_d = full_q;
        addr_d = addr_q;
        data_d = data_q;
        if (i_grant) begin
            full_d = 1'b0;
        end
        if (i_valid & ready) begin
            full_d = 1'b1;
            addr_d = i_addr;
            data_d = i_data;
        end
    end

    assign o_ready = ready;
    assign o_full  = full_q;
    assign o_addr  = addr_q;
    assign o_data  = data_q;

endmodule

// File: rtl/cg_rvarch_wb_arbiter.sv
// Writeback stage: round-robin merge of ALU and LSU results onto the single
// regfile write port, with a pending-destination mask for decode stalls.
module cg_rvarch_wb_arbiter
    import cg_rvarch_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int DATA_NUM   = REG_NUM
) (
    input logic                   i_clk,
    input logic                   i_rst,
    cg_rvarch_wb_arbiter_if.slave bus
);

    localparam int ADDR_W = $clog2(DATA_NUM);

    logic                  alu_full, lsu_full;
    logic                  grant_alu, grant_lsu, grant_any;
    logic [ADDR_W-1:0]     alu_addr, lsu_addr, gnt_addr;
    logic [DATA_WIDTH-1:0] alu_data, lsu_data, gnt_data;
    logic [DATA_NUM-1:0]   pend;

    wb_src_e               last_grant_q, last_grant_d;
    logic                  rd_we_q, rd_we_d;
    logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    cg_rvarch_wb_slot #(.ADDR_W(ADDR_W), .DATA_WIDTH(DATA_WIDTH)) u_alu_slot (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (bus.i_alu_valid),
        .i_addr  (bus.i_alu_rd_addr),
        .i_data  (bus.i_alu_data),
        .i_grant (grant_alu),
        .o_ready (bus.o_alu_ready),
        .o_full  (alu_full),
        .o_addr  (alu_addr),
        .o_data  (alu_data)
    );

    cg_rvarch_wb_slot #(.ADDR_W(ADDR_W), .DATA_WIDTH(DATA_WIDTH)) u_lsu_slot (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (bus.i_lsu_valid),
        .i_addr  (bus.i_lsu_rd_addr),
        .i_data  (bus.i_lsu_data),
        .i_grant (grant_lsu),
        .o_ready (bus.o_lsu_ready),
        .o_full  (lsu_full),
        .o_addr  (lsu_addr),
        .o_data  (lsu_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_grant_q <= WB_SRC_LSU;
            rd_we_q      <= 1'b0;
            rd_addr_q    <= '0;
            rd_data_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rd_we_q      <= rd_we_d;
            rd_addr_q    <= rd_addr_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Under contention the source that did not win last time goes first.
    always_comb begin
        grant_alu    = alu_full & (!lsu_full | (last_grant_q == WB_SRC_LSU));
        grant_lsu    = lsu_full & (!alu_full | (last_grant_q == WB_SRC_ALU));
        grant_any    = grant_alu | grant_lsu;
        gnt_addr     = grant_alu ? alu_addr : lsu_addr;
        gnt_data     = grant_alu ? alu_data : lsu_data;
        last_grant_d = last_grant_q;
        rd_addr_d    = rd_addr_q;
        rd_data_d    = rd_data_q;
        if (grant_alu) begin
            last_grant_d = WB_SRC_ALU;
        end else if (grant_lsu) begin
            last_grant_d = WB_SRC_LSU;
        end
        if (grant_any) begin
            rd_addr_d = gnt_addr;
            rd_data_d = gnt_data;
        end
        rd_we_d = grant_any & (gnt_addr != '0);
    end

    // x0 is never a real hazard, so its bit is forced clear.
    always_comb begin
        pend = '0;
        if (alu_full) pend[alu_addr] = 1'b1;
        if (lsu_full) pend[lsu_addr] = 1'b1;
        if (rd_we_q)  pend[rd_addr_q] = 1'b1;
        pend[0] = 1'b0;
    end

    assign bus.o_pend_mask = pend;
    assign bus.o_rd_we     = rd_we_q;
    assign bus.o_rd_addr   = rd_addr_q;
    assign bus.o_rd_data   = rd_data_q;

endmodule
